// File: rtl/takvim_pkg.sv
// Shared widths, limits and state encoding for the elapsed-time counter.
package takvim_pkg;

    localparam int YIL_W    = 4;
    localparam int GUN_W    = 11;
    localparam int SAAT_W   = 10;
    localparam int DAKIKA_W = 6;

    localparam logic [YIL_W-1:0]    YIL_MAX    = 4'd15;
    localparam logic [GUN_W-1:0]    GUN_MAX    = 11'd2047;
    localparam logic [SAAT_W-1:0]   SAAT_MAX   = 10'd23;
    localparam logic [DAKIKA_W-1:0] DAKIKA_MAX = 6'd59;

    typedef enum logic [1:0] {
        BOS  = 2'd0,
        SAY  = 2'd1,
        DOLU = 2'd2
    } durum_e;

endpackage

// File: rtl/dakika_bolucu.sv
// Minute prescaler: counts 0..59 and raises an hour strobe on the 59 -> 0 wrap.
module dakika_bolucu
    import takvim_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                i_sayim,
    input  logic                i_yukle,
    input  logic                i_dolu,
    output logic [DAKIKA_W-1:0] o_dakika,
    output logic                o_saat_strobe
);

    logic [DAKIKA_W-1:0] r_dakika;

    // Saturation pins the minute at 59 so the overflow edge looks unchanged.
    always_ff @(posedge clk) begin
        if (rst)
            r_dakika <= '0;
        else if (i_yukle)
            r_dakika <= '0;
        else if (i_dolu)
            r_dakika <= DAKIKA_MAX;
        else if (i_sayim)
            r_dakika <= (r_dakika == DAKIKA_MAX) ? '0 : r_dakika + 6'd1;
    end

    assign o_dakika      = r_dakika;
    assign o_saat_strobe = i_sayim && (r_dakika == DAKIKA_MAX);

endmodule

// File: rtl/takvim_sayac.sv
// Elapsed-time counter feeding the takvim decoder; TAKVIM_SAYAC_DAKIKA_EN adds a
// minute stage (dakika port) in front of the hour counter.
module takvim_sayac
    import takvim_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              tick,
    input  logic              yukle,
    input  logic              durdur,
    input  logic [YIL_W-1:0]  yil_in,
    input  logic [GUN_W-1:0]  gun_in,
    input  logic [SAAT_W-1:0] saat_in,
    output logic [YIL_W-1:0]  yil,
    output logic [GUN_W-1:0]  gun,
    output logic [SAAT_W-1:0] saat,
    output logic              gecerli,
    output logic              tasma,
    output logic [1:0]        durum
`ifdef TAKVIM_SAYAC_DAKIKA_EN
   ,output logic [DAKIKA_W-1:0] dakika
`endif
);

    durum_e            r_durum, w_durum_d;
    logic [YIL_W-1:0]  r_yil, w_yil_d;
    logic [GUN_W-1:0]  r_gun, w_gun_d;
    logic [SAAT_W-1:0] r_saat, w_saat_d;
    logic              r_gecerli;
    logic              w_say;
    logic              w_saat_inc;
    logic              w_saat_tas;
    logic              w_gun_tas;
    logic              w_tasma_olay;
    logic              w_degisti;

    // A tick only counts in SAY and loses to yukle and durdur.
    assign w_say = (r_durum == SAY) && tick && !yukle && !durdur;

`ifdef TAKVIM_SAYAC_DAKIKA_EN
    logic [DAKIKA_W-1:0] w_dakika;

    dakika_bolucu u_dakika_bolucu (
        .clk           (clk),
        .rst           (rst),
        .i_sayim       (w_say),
        .i_yukle       (yukle),
        .i_dolu        (w_tasma_olay),
        .o_dakika      (w_dakika),
        .o_saat_strobe (w_saat_inc)
    );

    assign dakika = w_dakika;
`else
    assign w_saat_inc = w_say;
`endif

    assign w_saat_tas   = (r_saat >= SAAT_MAX);
    assign w_gun_tas    = w_saat_tas && (r_gun == GUN_MAX);
    assign w_tasma_olay = w_saat_inc && w_gun_tas && (r_yil == YIL_MAX);

    always_ff @(posedge clk) begin
        if (rst)
            r_durum <= BOS;
        else
            r_durum <= w_durum_d;
    end

    always_comb begin
        w_durum_d = r_durum;
        if (yukle)
            w_durum_d = durdur ? BOS : SAY;
        else if (r_durum == SAY) begin
            if (durdur)
                w_durum_d = BOS;
            else if (w_tasma_olay)
                w_durum_d = DOLU;
        end
    end

    always_comb begin
        tasma = (r_durum == DOLU);
        durum = r_durum;
    end

    always_comb begin
        w_yil_d  = r_yil;
        w_gun_d  = r_gun;
        w_saat_d = r_saat;
        if (yukle) begin
            w_yil_d  = yil_in;
            w_gun_d  = gun_in;
            w_saat_d = saat_in;
        end else if (w_tasma_olay) begin
            w_gun_d  = GUN_MAX;
            w_saat_d = SAAT_MAX;
        end else if (w_saat_inc) begin
            w_saat_d = w_saat_tas ? '0 : r_saat + 10'd1;
            if (w_saat_tas)
                w_gun_d = w_gun_tas ? '0 : r_gun + 11'd1;
            if (w_gun_tas)
                w_yil_d = r_yil + 4'd1;
        end
    end

`ifdef TAKVIM_SAYAC_DAKIKA_EN
    // Every accepted minute tick moves dakika except the saturating one.
    assign w_degisti = (w_yil_d != r_yil) || (w_gun_d != r_gun) || (w_saat_d != r_saat)
                     || (w_say && !w_tasma_olay);
`else
    assign w_degisti = (w_yil_d != r_yil) || (w_gun_d != r_gun) || (w_saat_d != r_saat);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_yil     <= '0;
            r_gun     <= '0;
            r_saat    <= '0;
            r_gecerli <= 1'b0;
        end else begin
            r_yil     <= w_yil_d;
            r_gun     <= w_gun_d;
            r_saat    <= w_saat_d;
            r_gecerli <= yukle || w_degisti;
        end
    end

    assign yil     = r_yil;
    assign gun     = r_gun;
    assign saat    = r_saat;
    assign gecerli = r_gecerli;

endmodule

// File: tb/tb_takvim_sayac.sv
// Bench for takvim_sayac: directed vector table plus random traffic checked
// against a total-elapsed-time reference model.
module tb_takvim_sayac;

    logic        clk = 1'b0;
    logic        rst, tick, yukle, durdur;
    logic [3:0]  yil_in;
    logic [10:0] gun_in;
    logic [9:0]  saat_in;
    logic [3:0]  yil;
    logic [10:0] gun;
    logic [9:0]  saat;
    logic        gecerli, tasma;
    logic [1:0]  durum;
`ifdef TAKVIM_SAYAC_DAKIKA_EN
    logic [5:0]  dakika;
`endif

    int checks   = 0;
    int failures = 0;

    localparam int TOPLAM_MAX = 16 * 2048 * 24 - 1;

    takvim_sayac dut (
        .clk     (clk),
        .rst     (rst),
        .tick    (tick),
        .yukle   (yukle),
        .durdur  (durdur),
        .yil_in  (yil_in),
        .gun_in  (gun_in),
        .saat_in (saat_in),
        .yil     (yil),
        .gun     (gun),
        .saat    (saat),
        .gecerli (gecerli),
        .tasma   (tasma),
        .durum   (durum)
`ifdef TAKVIM_SAYAC_DAKIKA_EN
       ,.dakika  (dakika)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        bit r, y, d, t;
        int yi, gi, si;
        int ey, eg, es, ev, et, ed;
    } vek_t;

    function automatic vek_t mk(bit r, bit y, bit d, bit t, int yi, int gi, int si,
                                int ey, int eg, int es, int ev, int et, int ed);
        vek_t v;
        v.r = r; v.y = y; v.d = d; v.t = t;
        v.yi = yi; v.gi = gi; v.si = si;
        v.ey = ey; v.eg = eg; v.es = es; v.ev = ev; v.et = et; v.ed = ed;
        return v;
    endfunction

    task automatic chk(string nm, int act, int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
        end
    endtask

    // One clock: apply inputs, take the edge, sample 1ns later.
    task automatic cyc(bit r, bit y, bit d, bit t, int yi, int gi, int si);
        rst = r; yukle = y; durdur = d; tick = t;
        yil_in = 4'(yi); gun_in = 11'(gi); saat_in = 10'(si);
        @(posedge clk);
        #1;
    endtask

    // Reference model: calendar values as one elapsed count.
    int m_yil, m_gun, m_saat, m_dak, m_st, m_gec;

    task automatic m_saat_ilerle(output bit ovf);
        int s, t;
        s = (m_saat > 23) ? 23 : m_saat;
        t = (m_yil * 2048 + m_gun) * 24 + s;
        if (t == TOPLAM_MAX) begin
            ovf = 1'b1;
            m_saat = 23;
        end else begin
            ovf = 1'b0;
            t = t + 1;
            m_saat = t % 24;
            t = t / 24;
            m_gun = t % 2048;
            m_yil = t / 2048;
        end
    endtask

    task automatic m_adim(bit r, bit y, bit d, bit t, int yi, int gi, int si);
        int oy, og, os, od;
        bit ovf;
        oy = m_yil; og = m_gun; os = m_saat; od = m_dak;
        m_gec = 0;
        if (r) begin
            m_yil = 0; m_gun = 0; m_saat = 0; m_dak = 0; m_st = 0;
        end else if (y) begin
            m_yil = yi; m_gun = gi; m_saat = si; m_dak = 0;
            m_st = d ? 0 : 1;
            m_gec = 1;
        end else if (m_st == 1 && d) begin
            m_st = 0;
        end else if (m_st == 1 && t) begin
`ifdef TAKVIM_SAYAC_DAKIKA_EN
            if (m_dak < 59) m_dak++;
            else begin
                m_saat_ilerle(ovf);
                if (ovf) m_st = 2; else m_dak = 0;
            end
`else
            m_saat_ilerle(ovf);
            if (ovf) m_st = 2;
`endif
            m_gec = (oy != m_yil || og != m_gun || os != m_saat || od != m_dak) ? 1 : 0;
        end
    endtask

    vek_t tab[19];

    initial begin
        rst = 1'b1; tick = 1'b0; yukle = 1'b0; durdur = 1'b0;
        yil_in = '0; gun_in = '0; saat_in = '0;
        #2;

`ifndef TAKVIM_SAYAC_DAKIKA_EN
        //            r  y  d  t   yi   gi    si    ey   eg    es  gec tas dur
        tab[0]  = mk(1, 0, 0, 0,   0,    0,   0,    0,    0,   0, 0, 0, 0);
        tab[1]  = mk(0, 1, 0, 0,   3, 1000,  22,    3, 1000,  22, 1, 0, 1);
        tab[2]  = mk(0, 0, 0, 1,   0,    0,   0,    3, 1000,  23, 1, 0, 1);
        tab[3]  = mk(0, 0, 0, 1,   0,    0,   0,    3, 1001,   0, 1, 0, 1);
        tab[4]  = mk(0, 0, 0, 0,   0,    0,   0,    3, 1001,   0, 0, 0, 1);
        tab[5]  = mk(0, 1, 0, 0,   0,    0, 500,    0,    0, 500, 1, 0, 1);
        tab[6]  = mk(0, 0, 0, 1,   0,    0,   0,    0,    1,   0, 1, 0, 1);
        tab[7]  = mk(0, 1, 0, 0,  14, 2047,  23,   14, 2047,  23, 1, 0, 1);
        tab[8]  = mk(0, 0, 0, 1,   0,    0,   0,   15,    0,   0, 1, 0, 1);
        tab[9]  = mk(0, 1, 0, 0,  15, 2047,  23,   15, 2047,  23, 1, 0, 1);
        tab[10] = mk(0, 0, 0, 1,   0,    0,   0,   15, 2047,  23, 0, 1, 2);
        tab[11] = mk(0, 0, 0, 1,   0,    0,   0,   15, 2047,  23, 0, 1, 2);
        tab[12] = mk(0, 1, 0, 0,   5,   10,   3,    5,   10,   3, 1, 0, 1);
        tab[13] = mk(0, 0, 1, 1,   0,    0,   0,    5,   10,   3, 0, 0, 0);
        tab[14] = mk(0, 0, 0, 1,   0,    0,   0,    5,   10,   3, 0, 0, 0);
        tab[15] = mk(0, 1, 0, 1,   8,  358,   0,    8,  358,   0, 1, 0, 1);
        tab[16] = mk(0, 0, 0, 1,   0,    0,   0,    8,  358,   1, 1, 0, 1);
        tab[17] = mk(1, 1, 0, 1,   1,    1,   1,    0,    0,   0, 0, 0, 0);
        tab[18] = mk(0, 1, 1, 0,   2,    3,   4,    2,    3,   4, 1, 0, 0);

        for (int i = 0; i < 19; i++) begin
            cyc(tab[i].r, tab[i].y, tab[i].d, tab[i].t, tab[i].yi, tab[i].gi, tab[i].si);
            chk($sformatf("vec%0d_yil", i),     int'(yil),     tab[i].ey);
            chk($sformatf("vec%0d_gun", i),     int'(gun),     tab[i].eg);
            chk($sformatf("vec%0d_saat", i),    int'(saat),    tab[i].es);
            chk($sformatf("vec%0d_gecerli", i), int'(gecerli), tab[i].ev);
            chk($sformatf("vec%0d_tasma", i),   int'(tasma),   tab[i].et);
            chk($sformatf("vec%0d_durum", i),   int'(durum),   tab[i].ed);
        end
`else
        cyc(1, 0, 0, 0, 0, 0, 0);
        chk("rst_dakika", int'(dakika), 0);
        chk("rst_durum", int'(durum), 0);
        cyc(0, 1, 0, 0, 0, 0, 0);
        chk("load_durum", int'(durum), 1);
        for (int i = 1; i <= 60; i++) begin
            cyc(0, 0, 0, 1, 0, 0, 0);
            chk($sformatf("min%0d_dakika", i), int'(dakika), i % 60);
            chk($sformatf("min%0d_saat", i), int'(saat), (i == 60) ? 1 : 0);
            chk($sformatf("min%0d_gecerli", i), int'(gecerli), 1);
        end
`endif

        // Random traffic against the model, starting from reset.
        cyc(1, 0, 0, 0, 0, 0, 0);
        m_adim(1, 0, 0, 0, 0, 0, 0);
        for (int n = 0; n < 3000; n++) begin
            bit r, y, d, t;
            int yi, gi, si;
            r  = ($urandom_range(0, 99) == 0);
            y  = ($urandom_range(0, 24) == 0);
            d  = ($urandom_range(0, 39) == 0);
            t  = ($urandom_range(0, 3) != 0);
            yi = ($urandom_range(0, 2) == 0) ? 15 : $urandom_range(0, 15);
            gi = ($urandom_range(0, 1) == 0) ? $urandom_range(2040, 2047) : $urandom_range(0, 2047);
            si = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 1023) : $urandom_range(18, 23);
            cyc(r, y, d, t, yi, gi, si);
            m_adim(r, y, d, t, yi, gi, si);
            chk($sformatf("rnd%0d_yil", n),     int'(yil),     m_yil);
            chk($sformatf("rnd%0d_gun", n),     int'(gun),     m_gun);
            chk($sformatf("rnd%0d_saat", n),    int'(saat),    m_saat);
            chk($sformatf("rnd%0d_gecerli", n), int'(gecerli), m_gec);
            chk($sformatf("rnd%0d_tasma", n),   int'(tasma),   (m_st == 2) ? 1 : 0);
            chk($sformatf("rnd%0d_durum", n),   int'(durum),   m_st);
`ifdef TAKVIM_SAYAC_DAKIKA_EN
            chk($sformatf("rnd%0d_dakika", n),  int'(dakika),  m_dak);
`endif
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/takvim_sayac.md
# takvim_sayac

Sequential elapsed-time counter that sits directly upstream of the combinational calendar decoder `takvim`. It accumulates hour ticks into normalized `yil`/`gun`/`saat` registers, which drive the decoder's `yil`/`gun`/`saat` inputs. It supports a preload, pause, and overflow saturation, and pulses `gecerli` whenever the registered values change.

## Interface
Parameters:
- none. Limits are fixed constants in `takvim_pkg`.

Ports:
- `clk`  in  1  single system clock; all state updates on the rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `tick`  in  1  one-cycle time-unit strobe: an hour, or a minute with `TAKVIM_SAYAC_DAKIKA_EN`.
- `yukle`  in  1  load strobe; captures `yil_in`/`gun_in`/`saat_in`.
- `durdur`  in  1  pause request.
- `yil_in`  in  4  preload year.
- `gun_in`  in  11  preload day.
- `saat_in`  in  10  preload hour; any value is accepted.
- `yil`  out  4  registered year; feeds `takvim.yil`.
- `gun`  out  11  registered day; feeds `takvim.gun`.
- `saat`  out  10  registered hour, 0..23 after the first increment; feeds `takvim.saat`.
- `gecerli`  out  1  one-cycle pulse when any of `yil`/`gun`/`saat` (or `dakika`) changed at the last edge.
- `tasma`  out  1  overflow flag; high while in state DOLU.
- `durum`  out  2  current state: BOS=0, SAY=1, DOLU=2.
- `dakika`  out  6  minute register; present only with the macro.

## Operation
- States:
  - BOS: idle; ticks are ignored.
  - SAY: counting.
  - DOLU: saturated; ticks are ignored.
- State transitions:
  - `rst` goes to BOS.
  - `yukle` goes to SAY from any state.
  - In SAY, `durdur` goes to BOS.
  - In SAY, an overflow carry goes to DOLU.
- Priority within one cycle: `rst` > `yukle` > `durdur` > `tick`.
  - `yukle` and `tick` together: the load is applied and the tick is dropped.
  - `yukle` and `durdur` together: the load is applied and the next state is BOS.
  - `durdur` and `tick` in SAY: the tick is dropped.
- Load behaviour: `yil`/`gun`/`saat` take the inputs verbatim, `dakika` is set to 0, and `tasma` is cleared.
- Hour increment (a tick in SAY):
  - If `saat >= 23`: `saat` becomes 0 and a day carry is generated. This also normalizes out-of-range loaded values.
  - Otherwise: `saat` becomes `saat + 1`.
- Day carry:
  - If `gun == 2047`: `gun` becomes 0 and a year carry is generated.
  - Otherwise: `gun` becomes `gun + 1`.
- Year carry:
  - If `yil == 15`: registers hold at `yil=15`, `gun=2047`, `saat=23`, the state becomes DOLU, and `tasma` becomes 1.
  - Otherwise: `yil` becomes `yil + 1`.
- Overflow entry: `gecerli` is not pulsed on the overflow cycle, because the values are unchanged.
- Arithmetic: all compares are unsigned and the increments are width-exact. No wrap-around occurs except the explicit wraps above.

## Timing
- Reset values: `yil=0`, `gun=0`, `saat=0`, `dakika=0`, `gecerli=0`, `tasma=0`, `durum=BOS`.
- Latency: a `tick` or `yukle` sampled at edge N produces updated outputs and `gecerli=1` after edge N.
  - `gecerli` returns to 0 after edge N+1 unless another update occurs.
- Back-to-back ticks produce one increment per cycle, with no bubbles.
- `rst` asserted mid-count overrides everything on that edge.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Configuration
- `TAKVIM_SAYAC_DAKIKA_EN` defined:
  - The `dakika` port exists and `tick` counts minutes 0..59.
  - At `dakika == 59`, `dakika` wraps to 0 and an hour increment is applied in the same edge.
  - `gecerli` pulses on every minute change.
  - DOLU holds `dakika` at 59.
- Macro undefined:
  - There is no `dakika` port.
  - Each `tick` is one hour increment.

## Structure
- `takvim_pkg`:
  - State enum {BOS, SAY, DOLU}.
  - Constants `SAAT_MAX=23`, `GUN_MAX=2047`, `YIL_MAX=15`, `DAKIKA_MAX=59`.
  - Widths 4/11/10/6.
- Sub-module `dakika_bolucu`: the minute prescaler. It outputs an hour strobe and `dakika`, and is instantiated only under the macro.

## Test plan
1. Reset, then `yukle` with (3, 1000, 22), then 2 ticks → (3, 1000, 23), then (3, 1001, 0). `gecerli` pulses each time and `durum=SAY`.
2. Load (0, 0, 500), then 1 tick → `saat=0`, `gun=1`: out-of-range saat is normalized with a day carry.
3. Load (14, 2047, 23), then 1 tick → (15, 0, 0). Load (15, 2047, 23), then 1 tick → values hold, `tasma=1`, `durum=DOLU`, no `gecerli` pulse. A further tick causes no change.
4. In SAY, `durdur` and `tick` in the same cycle → values unchanged and `durum=BOS`. A later tick is ignored.
5. `yukle`(8, 358, 0) and `tick` in the same cycle → outputs (8, 358, 0) and SAY. Asserting `rst` mid-count → all zeros and BOS on the next edge.
6. With the macro: load (0, 0, 0), then 60 ticks → `dakika` 0..59, then 0 with `saat=1` on tick 60.
